// File: rtl/spi_slave_stream.sv
// spi_slave_stream: SPI slave serdes with valid/ready word streams.
// SPI pins are oversampled in the clk domain; all four SPI modes.
module spi_slave_stream #(
  parameter int WORD_WIDTH  = 40,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [WORD_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [WORD_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic                  clear_flags,
  output logic                  rx_overrun,
  output logic                  tx_underrun,
  output logic                  frame_abort,
  output logic                  frame_active,
  output logic [CNT_WIDTH-1:0]  frame_words,
  input  logic                  spi_SCLK,
  input  logic                  spi_SSEL,
  input  logic                  spi_MOSI,
  output logic                  spi_MISO
);

  localparam int   BW       = $clog2(WORD_WIDTH);
  localparam logic IDLE_LVL = (CPOL != 0);
  localparam logic PHA      = (CPHA != 0);
  localparam logic MSBF     = (MSB_FIRST != 0);
  localparam logic [BW-1:0] LAST = BW'(WORD_WIDTH - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state;

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] ssel_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic                   prev_sclk;
  logic                   prev_ssel;

  logic [BW-1:0]         bit_cnt;
  logic [WORD_WIDTH-1:0] rx_shift;
  logic [WORD_WIDTH-1:0] rx_next;
  logic [WORD_WIDTH-1:0] tx_shift;
  logic [WORD_WIDTH-1:0] hold;

  logic sclk_s, ssel_s, mosi_s;
  logic sclk_edge, lead, trail;
  logic sample_edge, shift_edge;
  logic ssel_fall, ssel_rise;
  logic active, busy;
  logic word_done, tx_load, tx_step;
  logic tx_capture, tx_out;
  logic ovr_set, und_set, abort_set;

  assign sclk_s = sclk_q[SYNC_STAGES-1];
  assign ssel_s = ssel_q[SYNC_STAGES-1];
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  // Pin synchronisers; reset to idle levels so release makes no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q    <= {SYNC_STAGES{IDLE_LVL}};
      ssel_q    <= '1;
      mosi_q    <= '0;
      prev_sclk <= IDLE_LVL;
      prev_ssel <= 1'b1;
    end else begin
      sclk_q    <= {sclk_q[SYNC_STAGES-2:0], spi_SCLK};
      ssel_q    <= {ssel_q[SYNC_STAGES-2:0], spi_SSEL};
      mosi_q    <= {mosi_q[SYNC_STAGES-2:0], spi_MOSI};
      prev_sclk <= sclk_s;
      prev_ssel <= ssel_s;
    end
  end

  // Edge classification and per-cycle word events.
  always_comb begin
    sclk_edge   = sclk_s != prev_sclk;
    lead        = sclk_edge && (sclk_s != IDLE_LVL);
    trail       = sclk_edge && (sclk_s == IDLE_LVL);
    sample_edge = PHA ? trail : lead;
    shift_edge  = PHA ? lead : trail;
    ssel_fall   = prev_ssel && !ssel_s;
    ssel_rise   = !prev_ssel && ssel_s;
    active      = state == ACTIVE;
    busy        = active && !ssel_rise;
    word_done   = busy && sample_edge && (bit_cnt == LAST);
    if (MSBF)
      rx_next = {rx_shift[WORD_WIDTH-2:0], mosi_s};
    else
      rx_next = {mosi_s, rx_shift[WORD_WIDTH-1:1]};
    tx_load = !active && ssel_fall;
    tx_step = 1'b0;
    if (PHA) begin
      tx_load = tx_load || word_done;
      tx_step = busy && shift_edge && (bit_cnt != '0);
    end else begin
      tx_load = tx_load || (busy && shift_edge && (bit_cnt == '0));
      tx_step = busy && shift_edge && (bit_cnt != '0);
    end
    tx_capture = tx_valid && tx_ready;
    tx_out     = MSBF ? tx_shift[WORD_WIDTH-1] : tx_shift[0];
    ovr_set    = word_done && rx_valid && !rx_ready;
    und_set    = tx_load && tx_ready;
    abort_set  = active && ssel_rise && (bit_cnt != '0);
  end

  // Frame FSM: select tracking, bit counting, RX assembly, word count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      frame_active <= 1'b0;
      frame_words  <= '0;
      rx_shift     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ssel_fall) begin
            state        <= ACTIVE;
            bit_cnt      <= '0;
            frame_words  <= '0;
            frame_active <= 1'b1;
            rx_shift     <= '0;
          end
        end
        ACTIVE: begin
          if (ssel_rise) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            frame_active <= 1'b0;
          end else if (sample_edge) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST) begin
              bit_cnt <= '0;
              if (frame_words != '1)
                frame_words <= frame_words + CNT_WIDTH'(1);
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
      endcase
    end
  end

  // TX holding register and its empty flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold     <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (tx_capture) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end else if (tx_load) begin
        tx_ready <= 1'b1;
      end
    end
  end

  // TX shift register: word loads at boundaries, else one-bit shifts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift <= '0;
    end else if (tx_load) begin
      tx_shift <= tx_ready ? '0 : hold;
    end else if (tx_step) begin
      if (MSBF)
        tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
      else
        tx_shift <= {1'b0, tx_shift[WORD_WIDTH-1:1]};
    end
  end

  // Registered MISO, forced low outside a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      spi_MISO <= 1'b0;
    else
      spi_MISO <= active ? tx_out : 1'b0;
  end

  // RX output word and its valid/ready handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (word_done && (!rx_valid || rx_ready)) begin
      rx_data  <= rx_next;
      rx_valid <= 1'b1;
    end else if (rx_ready) begin
      rx_valid <= 1'b0;
    end
  end

  // Sticky flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      rx_overrun  <= ovr_set   || (rx_overrun  && !clear_flags);
      tx_underrun <= und_set   || (tx_underrun && !clear_flags);
      frame_abort <= abort_set || (frame_abort && !clear_flags);
    end
  end

endmodule

// File: doc/spi_slave_stream.md
Name: spi_slave_stream

Overview:
- Parametrised SPI slave serialiser/deserialiser for host-to-FPGA control and metering traffic.
- Successor to the fixed-mode 40-bit serdes. Adds:
  - all four SPI modes (CPOL/CPHA);
  - configurable word width and LSB/MSB order;
  - multi-word bursts within one select;
  - valid/ready handshakes on both directions, with overrun/underrun flags.
- Sits between the SPI pins and the register/command decoder, entirely in the `clk` domain.

Parameters:
- WORD_WIDTH, 40: bits per word (2..64).
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- MSB_FIRST, 1: 1 = MSB shifted first on both MOSI and MISO; 0 = LSB first.
- SYNC_STAGES, 2: flip-flop stages on SCLK/SSEL/MOSI (≥2).
- CNT_WIDTH, 8: width of frame_words.

Ports:
- clk  in  1  system clock; must be ≥8× SCLK.
- reset_n  in  1  asynchronous active-low reset.
- tx_data  in  WORD_WIDTH  next word to send on MISO.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-entry TX holding register empty.
- rx_data  out  WORD_WIDTH  last received word.
- rx_valid  out  1  rx_data holds an unaccepted word.
- rx_ready  in  1  consumer accepts rx_data.
- clear_flags  in  1  clears sticky flags.
- rx_overrun  out  1  sticky: completed word dropped because rx_valid was still held.
- tx_underrun  out  1  sticky: word boundary reached with TX holding register empty.
- frame_abort  out  1  sticky: SSEL deasserted with a partial word.
- frame_active  out  1  synchronised select asserted.
- frame_words  out  CNT_WIDTH  words completed in current frame; saturating.
- spi_SCLK  in  1  SPI clock.
- spi_SSEL  in  1  slave select; low = selected.
- spi_MOSI  in  1  data in.
- spi_MISO  out  1  data out.

Behaviour:
- Reset values (reset_n low):
  - rx_valid, tx_underrun, rx_overrun, frame_abort, frame_active = 0.
  - rx_data, frame_words, shift registers, bit counter = 0.
  - tx_ready = 1, spi_MISO = 0.
  - Synchroniser and prev_sclk are set to CPOL / 1 / 0 (sclk / ssel / mosi) so no false edge occurs on release.
- Edge detection:
  - leading = synced sclk transitions away from CPOL; trailing = transitions back to CPOL.
  - An edge is detected in the cycle synced sclk != prev_sclk. Its register effects are visible the next cycle.
- State machine, IDLE → ACTIVE:
  - Entered on synced ssel falling.
  - On entry: bit counter = 0, frame_words = 0, frame_active = 1.
  - The TX shift register loads from the holding register if full (tx_ready goes to 1). If the holding register is empty it loads zeros and sets tx_underrun.
- State machine, ACTIVE → IDLE:
  - Taken on synced ssel rising; frame_active = 0.
  - If bit counter != 0, the partial RX word is discarded and frame_abort is set.
  - Counter resets. Holding register contents are retained.
- Sample edge:
  - MOSI is shifted into the RX shift register (order per MSB_FIRST) and the bit counter increments.
  - When the counter reaches WORD_WIDTH, it wraps to 0, the assembled word is completed, and frame_words increments (holding at all-ones).
- Shift edge:
  - The TX shift register advances by one.
  - Word boundary, CPHA=0: the first trailing edge after a word completes loads the next word instead of shifting.
  - Word boundary, CPHA=1: the load happens on the completing (trailing) sample edge itself, and the first leading edge of each word does not shift.
  - Underrun handling at every boundary is the same as at frame entry.
- spi_MISO = the TX shift register bit at the output end, registered. It drives 0 in IDLE.
- RX handshake:
  - On word completion, if rx_valid=0 or rx_ready=1 in that cycle: rx_data is updated and rx_valid=1 the next cycle.
  - Otherwise the new word is dropped, rx_data is unchanged, and rx_overrun is set.
  - rx_valid clears after a cycle with rx_ready=1 and no new completion.
- TX handshake: the holding register captures tx_data when tx_valid && tx_ready. If a load into the shift register and a capture occur in the same cycle, the shift register takes the old holding contents and the holding register takes the new word; tx_ready stays 0.
- clear_flags clears all sticky flags. A flag set in the same cycle as clear_flags wins (flag = 1).
- SCLK edges while in IDLE are ignored.

Test Plan:
- Mode 0, WORD_WIDTH=40: preload tx 0xA5_0000_0001, send MOSI 0x12_3456_789A → rx_data=0x123456789A with one rx_valid rise; MISO bitstream = 0xA500000001 MSB-first; tx_ready returns 1 at frame start.
- Repeat the same transfer in all of modes 1–3 and with MSB_FIRST=0 → identical rx_data/MISO word values; bit order reversed for LSB-first.
- 3-word burst with rx_ready held low → first word is kept, rx_overrun=1 after word 2, frame_words=3, and the tx_underrun flag records that tx was empty at boundaries 2 and 3.
- SSEL deasserted after 17 bits → frame_abort=1, rx_valid stays 0, the next full frame is received correctly.
- reset_n pulsed low mid-word → all outputs return to reset values immediately; with SCLK idling at CPOL there is no spurious edge after release.
- clear_flags coinciding with a new overrun → rx_overrun remains 1.
